mem_arbiter: RTL

Arbitrates the single shared program/data memory between the CPU control unit and a DMA/loader port. Each requester issues one read or write at a time with a req/ack handshake. The arbiter grants round-robin, drives the memory for a fixed access latency, and returns read data with a one-cycle acknowledge. It sits between the CPU datapath/controller and the memory, replacing direct CPU memory strobes.

---
 rtl/vn_bus_pkg.sv | 26 ++
 rtl/mem_arbiter_if.sv | 63 ++++++
 rtl/arb_rr2.sv | 46 ++++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/vn_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vn_bus_pkg
//  Description : Shared types and constants for the memory arbiter slice:
//                FSM state encoding, requester identifiers, default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package vn_bus_pkg;

    // Default bus widths
    localparam int DEF_AW = 6;
    localparam int DEF_DW = 8;

    // Requester identifiers, also the encoding of the owner output
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage : vn_bus_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundle of the two requester ports (CPU, DMA), the shared
//                memory port and the arbiter status signals.
//                slave  = arbiter view, master = environment view
//                (requesters and memory).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int AW = vn_bus_pkg::DEF_AW,
    parameter int DW = vn_bus_pkg::DEF_DW
) ();

    // CPU requester
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    // DMA / loader requester
    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_ack;
    logic [DW-1:0] dma_rdata;

    // Shared memory
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Status
    logic          busy;
    logic          owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_ack, dma_rdata,
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_ack, dma_rdata,
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, owner
    );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/arb_rr2.sv
`default_nettype none
// ============================================================================
//  Module      : arb_rr2
//  Description : Combinational two-way round-robin picker. One requester can
//                be excluded (the owner still holding req during its ack
//                cycle). On a tie the requester that did not win last time
//                is chosen.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_rr2
    import vn_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    input  logic       exclude_valid,
    input  logic       exclude_id,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic [1:0] excl_mask;
    logic [1:0] eligible;

    // Requests that may win this cycle
    always_comb begin
        excl_mask = 2'b00;
        if (exclude_valid) begin
            excl_mask[exclude_id] = 1'b1;
        end
        eligible = req & ~excl_mask;
    end

    // Pick: single eligible wins outright, a tie goes to the non-last owner
    always_comb begin
        gnt_valid = |eligible;
        gnt_id    = OWN_CPU;
        unique case (eligible)
            2'b01:   gnt_id = OWN_CPU;
            2'b10:   gnt_id = OWN_DMA;
            2'b11:   gnt_id = ~last_owner;
            default: gnt_id = OWN_CPU;
        endcase
    end

endmodule : arb_rr2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Round-robin arbiter between the CPU and a DMA/loader port
//                for a single shared memory with a fixed access latency.
//                IDLE -> ACCESS (MEM_LAT cycles) -> RESP (one-cycle ack).
//                From RESP the other requester may be granted directly,
//                so alternating owners run without an IDLE bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import vn_bus_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int MEM_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,      // asynchronous, active low
    mem_arbiter_if.slave bus
);

    localparam int            CW       = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LAT_INIT = CW'(MEM_LAT - 1);

    state_t        state;
    logic [CW-1:0] lat_cnt;
    logic          last_owner;

    // Registered outputs
    logic          owner;
    logic          busy;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          cpu_ack;
    logic          dma_ack;
    logic [DW-1:0] cpu_rdata;
    logic [DW-1:0] dma_rdata;

    // Arbitration
    logic [1:0]    req_vec;
    logic          excl_valid;
    logic          gnt_valid;
    logic          gnt_id;
    logic          grant_now;

    // Winner's transaction
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    assign req_vec    = {bus.dma_req, bus.cpu_req};
    // In RESP the owner still holds req for the transaction just finishing
    assign excl_valid = (state == ST_RESP);
    assign grant_now  = gnt_valid && ((state == ST_IDLE) || (state == ST_RESP));

    arb_rr2 u_arb (
        .req           (req_vec),
        .last_owner    (last_owner),
        .exclude_valid (excl_valid),
        .exclude_id    (owner),
        .gnt_valid     (gnt_valid),
        .gnt_id        (gnt_id)
    );

    // Route the winning requester's command to the memory registers
    always_comb begin
        sel_we    = bus.cpu_we;
        sel_addr  = bus.cpu_addr;
        sel_wdata = bus.cpu_wdata;
        if (gnt_id == OWN_DMA) begin
            sel_we    = bus.dma_we;
            sel_addr  = bus.dma_addr;
            sel_wdata = bus.dma_wdata;
        end
    end

    // Arbiter FSM with all outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            lat_cnt    <= '0;
            last_owner <= OWN_DMA;
            owner      <= OWN_CPU;
            busy       <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            case (state)
                ST_IDLE, ST_RESP: begin
                    if (grant_now) begin
                        mem_addr   <= sel_addr;
                        mem_wdata  <= sel_wdata;
                        mem_wr     <= sel_we;
                        mem_rd     <= ~sel_we;
                        owner      <= gnt_id;
                        last_owner <= gnt_id;
                        lat_cnt    <= LAT_INIT;
                        busy       <= 1'b1;
                        state      <= ST_ACCESS;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (lat_cnt == '0) begin
                        // Memory data is valid in the last access cycle
                        if (mem_rd) begin
                            if (owner == OWN_DMA) begin
                                dma_rdata <= bus.mem_rdata;
                            end else begin
                                cpu_rdata <= bus.mem_rdata;
                            end
                        end
                        mem_rd  <= 1'b0;
                        mem_wr  <= 1'b0;
                        cpu_ack <= (owner == OWN_CPU);
                        dma_ack <= (owner == OWN_DMA);
                        state   <= ST_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                default: begin
                    busy   <= 1'b0;
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.owner     = owner;
    assign bus.busy      = busy;
    assign bus.mem_rd    = mem_rd;
    assign bus.mem_wr    = mem_wr;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.cpu_ack   = cpu_ack;
    assign bus.dma_ack   = dma_ack;
    assign bus.cpu_rdata = cpu_rdata;
    assign bus.dma_rdata = dma_rdata;

endmodule : mem_arbiter
`default_nettype wire
